// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Purpose: one-bit full adder, the only arithmetic in the serial adder.
// Latency/backpressure: purely combinational, no handshake.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Purpose: LSB-first bit-serial a+b+cin; result valid WIDTH cycles after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_in_ready;
    logic             w_out_valid;

    full_adder u_fa (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_next = w_s;
        end else begin : g_wn
            assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next_state = ADD;
            end
            ADD: begin
                if (r_cnt == CW'(WIDTH - 1)) w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign sum       = r_sum_sr;
    assign cout      = r_carry;

endmodule
